sram_bank: RTL and testbench

SRAM_BANK -- requirements
Module: sram_bank

---
 rtl/sram_pkg.sv | 24 ++
 rtl/sram_outreg.sv | 30 +++
 rtl/sram_bank.sv | 141 ++++++++++++++
 tb/tb_sram_bank.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the SRAM bank: collision mode, controller state
// and the byte-enable merge used on the write path.
package sram_pkg;

   typedef enum logic {WRITE_FIRST, READ_FIRST} collision_e;

   typedef enum logic {INIT, READY} state_e;

   localparam int MERGE_W = 1024;
   localparam int MERGE_B = MERGE_W / 8;

   // Lanes with be=1 take the new byte, the rest keep the old one.
   function automatic logic [MERGE_W-1:0] beMerge(input logic [MERGE_W-1:0] oldWord,
                                                  input logic [MERGE_W-1:0] newWord,
                                                  input logic [MERGE_B-1:0] be);
      logic [MERGE_W-1:0] res;
      res = oldWord;
      for (int i = 0; i < MERGE_B; i++) begin
         if (be[i]) res[8*i +: 8] = newWord[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/sram_outreg.sv
// Optional output register stage: adds one cycle of read latency and holds
// the last valid word while no new read data arrives.
module sram_outreg #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          vld_i,
   input  logic [DW-1:0] data_i,
   output logic          vld_o,
   output logic [DW-1:0] data_o
);

   logic          vld_q;
   logic [DW-1:0] data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         data_q <= '0;
      end else begin
         vld_q <= vld_i;
         if (vld_i) data_q <= data_i;
      end
   end

   assign vld_o  = vld_q;
   assign data_o = data_q;

endmodule

// File: rtl/sram_bank.sv
// Single-port-write / single-port-read SRAM bank with byte enables, zero-fill
// after reset, configurable collision behaviour and optional output register.
module sram_bank
   import sram_pkg::*;
#(
   parameter int         AW         = 8,
   parameter int         DW         = 32,
   parameter int         DEPTH      = 256,
   parameter int         REGOUT     = 1,
   parameter collision_e COLLISION  = WRITE_FIRST,
   parameter int         INIT_CLEAR = 1
) (
   input  logic          memclk,
   input  logic          memrst_n,
   input  logic          cs,
   input  logic          wren,
   input  logic [DW/8-1:0] be,
   input  logic [AW-1:0] memwaddr,
   input  logic [DW-1:0] din,
   input  logic          rden,
   input  logic [AW-1:0] memraddr,
   output logic [DW-1:0] dout,
   output logic          dout_vld,
   output logic          ready,
   output logic          oob_err
);

   if (DW % 8 != 0 || DW > MERGE_W) begin : g_dwCheck
      $error("sram_bank: DW must be a multiple of 8 and at most %0d", MERGE_W);
   end
   if (DEPTH < 1 || (AW < 31 && DEPTH > (1 << AW))) begin : g_depthCheck
      $error("sram_bank: DEPTH must be in 1..2**AW");
   end

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_e        state_q;
   logic [AW-1:0] initCnt_q;
   logic          ready_q;
   logic          rdVld_q;
   logic [DW-1:0] rdData_q;
   logic          oob_q;

   logic [DW-1:0] mem [DEPTH];

   logic [31:0]        waddrExt;
   logic [31:0]        raddrExt;
   logic               wInRange;
   logic               rInRange;
   logic               wrAcc;
   logic               rdAcc;
   logic               oobNow;
   logic [MERGE_W-1:0] mergedWide;
   logic [DW-1:0]      newWord;
   logic               unusedMergeBits;

   assign waddrExt = 32'(memwaddr);
   assign raddrExt = 32'(memraddr);
   assign wInRange = waddrExt < 32'(DEPTH);
   assign rInRange = raddrExt < 32'(DEPTH);

   assign wrAcc  = ready_q && cs && wren && wInRange;
   assign rdAcc  = ready_q && cs && rden && rInRange;
   assign oobNow = ready_q && cs && ((wren && !wInRange) || (rden && !rInRange));

   assign mergedWide      = beMerge(MERGE_W'(mem[memwaddr]), MERGE_W'(din), MERGE_B'(be));
   assign newWord         = mergedWide[DW-1:0];
   assign unusedMergeBits = ^mergedWide;

   // Controller: sweep the clear counter through the array, then sit in READY.
   always_ff @(posedge memclk or negedge memrst_n) begin
      if (!memrst_n) begin
         state_q   <= INIT;
         initCnt_q <= '0;
         ready_q   <= 1'b0;
      end else begin
         case (state_q)
            INIT: begin
               if (INIT_CLEAR == 0 || initCnt_q == LAST_ADDR) begin
                  state_q <= READY;
                  ready_q <= 1'b1;
               end else begin
                  initCnt_q <= initCnt_q + 1'b1;
               end
            end
            READY: begin
               state_q <= READY;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= INIT;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // The array has no reset of its own; only the INIT sweep clears it.
   always_ff @(posedge memclk) begin
      if (state_q == INIT) begin
         if (INIT_CLEAR != 0) mem[initCnt_q] <= '0;
      end else if (wrAcc) begin
         mem[memwaddr] <= newWord;
      end
   end

   always_ff @(posedge memclk or negedge memrst_n) begin
      if (!memrst_n) begin
         rdVld_q  <= 1'b0;
         rdData_q <= '0;
         oob_q    <= 1'b0;
      end else begin
         rdVld_q <= rdAcc;
         oob_q   <= oobNow;
         if (rdAcc) begin
            if (COLLISION == WRITE_FIRST && wrAcc && memwaddr == memraddr)
               rdData_q <= newWord;
            else
               rdData_q <= mem[memraddr];
         end
      end
   end

   if (REGOUT != 0) begin : g_regout
      sram_outreg #(.DW(DW)) u_outreg (
         .clk    (memclk),
         .rst_n  (memrst_n),
         .vld_i  (rdVld_q),
         .data_i (rdData_q),
         .vld_o  (dout_vld),
         .data_o (dout)
      );
   end else begin : g_direct
      assign dout_vld = rdVld_q;
      assign dout     = rdData_q;
   end

   assign ready   = ready_q;
   assign oob_err = oob_q;

endmodule

// File: tb/tb_sram_bank.sv
// Scoreboard bench for sram_bank: two instances (registered/write-first and
// direct/read-first) share one stimulus stream and are checked independently.
module tb_sram_bank;
   import sram_pkg::*;

   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int DEPTH = 200;

   logic          memclk   = 1'b0;
   logic          memrst_n = 1'b0;
   logic          cs       = 1'b0;
   logic          wren     = 1'b0;
   logic          rden     = 1'b0;
   logic [3:0]    be       = 4'h0;
   logic [AW-1:0] memwaddr = '0;
   logic [AW-1:0] memraddr = '0;
   logic [DW-1:0] din      = '0;

   logic [DW-1:0] doutA, doutB;
   logic          vldA, vldB, readyA, readyB, oobA, oobB;

   sram_bank #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .REGOUT(1), .COLLISION(WRITE_FIRST),
               .INIT_CLEAR(1)) dutA (
      .memclk(memclk), .memrst_n(memrst_n), .cs(cs), .wren(wren), .be(be),
      .memwaddr(memwaddr), .din(din), .rden(rden), .memraddr(memraddr),
      .dout(doutA), .dout_vld(vldA), .ready(readyA), .oob_err(oobA));

   sram_bank #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .REGOUT(0), .COLLISION(READ_FIRST),
               .INIT_CLEAR(1)) dutB (
      .memclk(memclk), .memrst_n(memrst_n), .cs(cs), .wren(wren), .be(be),
      .memwaddr(memwaddr), .din(din), .rden(rden), .memraddr(memraddr),
      .dout(doutB), .dout_vld(vldB), .ready(readyB), .oob_err(oobB));

   always #5 memclk = ~memclk;

   int cyc = 0;
   always @(posedge memclk) cyc++;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t dq[2][$];
   int   oq[2][$];
   int   nCmp = 0;
   int   nFail = 0;
   logic modelReady = 1'b0;

   logic          vldS[2];
   logic          oobS[2];
   logic [DW-1:0] doS[2];
   assign vldS[0] = vldA;  assign vldS[1] = vldB;
   assign oobS[0] = oobA;  assign oobS[1] = oobB;
   assign doS[0]  = doutA; assign doS[1]  = doutB;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every dout_vld / oob_err pulse must match the head of its queue.
   always @(negedge memclk) begin
      exp_t e;
      int   oc;
      for (int i = 0; i < 2; i++) begin
         if (vldS[i] === 1'b1) begin
            if (dq[i].size() == 0) begin
               checkOutput($sformatf("dut%0d spurious dout_vld", i), 32'd1, 32'd0);
            end else begin
               e = dq[i].pop_front();
               checkOutput($sformatf("dut%0d read data", i), doS[i], e.data);
               checkOutput($sformatf("dut%0d read latency", i), 32'(cyc), 32'(e.cyc));
            end
         end else if (dq[i].size() > 0 && dq[i][0].cyc < cyc) begin
            e = dq[i].pop_front();
            checkOutput($sformatf("dut%0d missing dout_vld", i), 32'd0, 32'd1);
         end
         if (oobS[i] === 1'b1) begin
            if (oq[i].size() == 0) begin
               checkOutput($sformatf("dut%0d spurious oob_err", i), 32'd1, 32'd0);
            end else begin
               oc = oq[i].pop_front();
               checkOutput($sformatf("dut%0d oob_err timing", i), 32'(cyc), 32'(oc));
            end
         end else if (oq[i].size() > 0 && oq[i][0] < cyc) begin
            oc = oq[i].pop_front();
            checkOutput($sformatf("dut%0d missing oob_err", i), 32'd0, 32'd1);
         end
      end
   end

   task automatic cycle();
      @(posedge memclk);
      #1;
   endtask

   task automatic idle(input int n);
      cs = 1'b0; wren = 1'b0; rden = 1'b0;
      repeat (n) cycle();
   endtask

   // One request cycle; expA is the registered/write-first result, expB the direct/read-first one.
   task automatic applyStimulus(input logic w, input logic r, input logic [7:0] wa,
                                input logic [7:0] ra, input logic [31:0] d, input logic [3:0] b,
                                input logic [31:0] expA, input logic [31:0] expB);
      cs = 1'b1; wren = w; rden = r; memwaddr = wa; memraddr = ra; din = d; be = b;
      if (modelReady && r && int'(ra) < DEPTH) begin
         dq[0].push_back('{data: expA, cyc: cyc + 2});
         dq[1].push_back('{data: expB, cyc: cyc + 1});
      end
      if (modelReady && ((w && int'(wa) >= DEPTH) || (r && int'(ra) >= DEPTH))) begin
         oq[0].push_back(cyc + 1);
         oq[1].push_back(cyc + 1);
      end
      cycle();
   endtask

   task automatic doReset(input int hold, output int relCyc);
      @(posedge memclk);
      #3;
      memrst_n = 1'b0;
      cs = 1'b0; wren = 1'b0; rden = 1'b0;
      modelReady = 1'b0;
      dq[0].delete(); dq[1].delete(); oq[0].delete(); oq[1].delete();
      #1;
      checkOutput("reset dout A", doutA, 32'h0);
      checkOutput("reset dout B", doutB, 32'h0);
      checkOutput("reset vld A", 32'(vldA), 32'd0);
      checkOutput("reset vld B", 32'(vldB), 32'd0);
      checkOutput("reset ready A", 32'(readyA), 32'd0);
      checkOutput("reset ready B", 32'(readyB), 32'd0);
      checkOutput("reset oob A", 32'(oobA), 32'd0);
      checkOutput("reset oob B", 32'(oobB), 32'd0);
      repeat (hold) @(posedge memclk);
      #1;
      memrst_n = 1'b1;
      relCyc = cyc;
   endtask

   task automatic waitReady(input int relCyc);
      @(negedge memclk);
      while (readyA !== 1'b1 && cyc <= relCyc + DEPTH + 50) @(negedge memclk);
      checkOutput("ready rise delay", 32'(cyc - relCyc), 32'(DEPTH));
      checkOutput("ready B", 32'(readyB), 32'd1);
      cs = 1'b0; wren = 1'b0; rden = 1'b0;
      modelReady = 1'b1;
      @(posedge memclk);
      #1;
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      nFail++;
      $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int rel;
      doReset(3, rel);

      // Requests during INIT must be dropped: no vld, no oob_err.
      cs = 1'b1; rden = 1'b1; memraddr = 8'd3; wren = 1'b1; memwaddr = 8'd250;
      din = 32'hFFFF_FFFF; be = 4'hF;
      waitReady(rel);

      for (int i = 0; i < DEPTH; i++)
         applyStimulus(1'b0, 1'b1, 8'd0, 8'(i), 32'h0, 4'h0, 32'h0, 32'h0);
      idle(4);

      applyStimulus(1'b1, 1'b0, 8'd5, 8'd0, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 8'd5, 8'd0, 32'h1122_3344, 4'b0101, 32'h0, 32'h0);
      applyStimulus(1'b0, 1'b1, 8'd0, 8'd5, 32'h0, 4'h0, 32'hDE22_BE44, 32'hDE22_BE44);
      idle(4);
      checkOutput("dout hold A", doutA, 32'hDE22_BE44);
      checkOutput("dout hold B", doutB, 32'hDE22_BE44);

      applyStimulus(1'b1, 1'b1, 8'd9, 8'd9, 32'hA5A5_A5A5, 4'hF, 32'hA5A5_A5A5, 32'h0);
      applyStimulus(1'b1, 1'b1, 8'd10, 8'd10, 32'hA5A5_A5A5, 4'b0011, 32'h0000_A5A5, 32'h0);
      applyStimulus(1'b0, 1'b1, 8'd0, 8'd9, 32'h0, 4'h0, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
      applyStimulus(1'b0, 1'b1, 8'd0, 8'd10, 32'h0, 4'h0, 32'h0000_A5A5, 32'h0000_A5A5);
      idle(3);

      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 1'b0, 8'(i), 8'd0, 32'hC0DE_0000 | 32'(i), 4'hF, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, 1'b1, 8'd0, 8'(i), 32'h0, 4'h0, 32'hC0DE_0000 | 32'(i),
                       32'hC0DE_0000 | 32'(i));
      idle(4);

      applyStimulus(1'b0, 1'b1, 8'd0, 8'd250, 32'h0, 4'h0, 32'h0, 32'h0);
      idle(2);
      applyStimulus(1'b1, 1'b0, 8'd250, 8'd0, 32'h5A5A_5A5A, 4'hF, 32'h0, 32'h0);
      idle(2);
      applyStimulus(1'b0, 1'b1, 8'd0, 8'd50, 32'h0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b0, 1'b1, 8'd0, 8'd122, 32'h0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b0, 1'b1, 8'd0, 8'd199, 32'h0, 4'h0, 32'h0, 32'h0);
      idle(4);

      // Reset in the middle of a read burst, then again partway through INIT.
      applyStimulus(1'b0, 1'b1, 8'd0, 8'd0, 32'h0, 4'h0, 32'hC0DE_0000, 32'hC0DE_0000);
      applyStimulus(1'b0, 1'b1, 8'd0, 8'd1, 32'h0, 4'h0, 32'hC0DE_0001, 32'hC0DE_0001);
      cs = 1'b1; rden = 1'b1; memraddr = 8'd2;
      doReset(2, rel);
      repeat (50) cycle();
      doReset(2, rel);
      waitReady(rel);

      applyStimulus(1'b0, 1'b1, 8'd0, 8'd5, 32'h0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b0, 1'b1, 8'd0, 8'd1, 32'h0, 4'h0, 32'h0, 32'h0);
      idle(5);

      checkOutput("dutA read queue drained", 32'(dq[0].size()), 32'd0);
      checkOutput("dutB read queue drained", 32'(dq[1].size()), 32'd0);
      checkOutput("oob queues drained", 32'(oq[0].size() + oq[1].size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
      $finish;
   end

endmodule
